// File: rtl/yonga_can_tx_engine_if.sv
// CAN TX engine bundle: sys-ctrl, packetizer, bit timing, bus.
// YONGA_CAN_TEC_EN adds o_tec / o_err_passive.
interface yonga_can_tx_engine_if #(
  parameter int RW = 2
);
  logic          i_config_enable;
  logic          i_sys_ctrl_sts_send;
  logic          i_pulse_gen_synced;
  logic          i_drive_pulse;
  logic          i_sample_pulse;
  logic          i_message_bit;
  logic          i_packetizer_message_bit;
  logic          i_packetizer_rdy;
  logic          i_ack_slot;
  logic          o_packetizer_en;
  logic          o_pulse_gen_en;
  logic          o_message_bit;
  logic [2:0]    o_sts_code;
  logic          o_sts_valid;
  logic [RW-1:0] o_retry_cnt;
`ifdef YONGA_CAN_TEC_EN
  logic [8:0]    o_tec;
  logic          o_err_passive;
`endif

  modport slave (
    input  i_config_enable,
    input  i_sys_ctrl_sts_send,
    input  i_pulse_gen_synced,
    input  i_drive_pulse,
    input  i_sample_pulse,
    input  i_message_bit,
    input  i_packetizer_message_bit,
    input  i_packetizer_rdy,
    input  i_ack_slot,
    output o_packetizer_en,
    output o_pulse_gen_en,
    output o_message_bit,
    output o_sts_code,
    output o_sts_valid,
    output o_retry_cnt
`ifdef YONGA_CAN_TEC_EN
    , output o_tec
    , output o_err_passive
`endif
  );

  modport master (
    output i_config_enable,
    output i_sys_ctrl_sts_send,
    output i_pulse_gen_synced,
    output i_drive_pulse,
    output i_sample_pulse,
    output i_message_bit,
    output i_packetizer_message_bit,
    output i_packetizer_rdy,
    output i_ack_slot,
    input  o_packetizer_en,
    input  o_pulse_gen_en,
    input  o_message_bit,
    input  o_sts_code,
    input  o_sts_valid,
    input  o_retry_cnt
`ifdef YONGA_CAN_TEC_EN
    , input o_tec
    , input o_err_passive
`endif
  );
endinterface

// File: rtl/yonga_can_tx_engine.sv
// CAN TX sequencer: idle detect, bit drive/check, arbitration, error frames, retries.
// Define YONGA_CAN_TEC_EN for the transmit error counter and bus-off state.
module yonga_can_tx_engine #(
  parameter int IDLE_BITS      = 11,
  parameter int IFS_BITS       = 3,
  parameter int MAX_RETRIES    = 3,
  parameter int ERR_FLAG_BITS  = 6,
  parameter int ERR_DELIM_BITS = 8,
  parameter int CNT_W          = 6
) (
  input logic i_controller_clk,
  input logic i_controller_rst_n,
  yonga_can_tx_engine_if.slave bus
);
  localparam int RW =
    (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_SYNC,
    S_WAIT,
    S_ARM,
    S_DRIVE,
    S_SAMPLE,
    S_FLAG,
    S_DELIM,
    S_IFS
`ifdef YONGA_CAN_TEC_EN
    , S_BUS_OFF
`endif
  } state_t;

  state_t         state, state_n;
  logic [CNT_W-1:0] ones, ones_n;
  logic [CNT_W-1:0] bcnt, bcnt_n;
  logic [CNT_W-1:0] ecnt, ecnt_n;
  logic           tx, tx_n;
  logic           ide, ide_n;
  logic           ok, ok_n;
  logic [RW-1:0]  retry, retry_n;
  logic [2:0]     code, code_n;
  logic           vld, vld_n;
  logic           msg, msg_n;
  logic           pkt, pkt_n;
  logic           pg, pg_n;
  logic           err_hit, fail, fail_ifs;
  logic           abort;
  logic [RW:0]    retry_inc;
  logic [CNT_W-1:0] arb;

  logic cfg, send, drv, smp, rx, pbit;
  assign cfg  = bus.i_config_enable;
  assign send = bus.i_sys_ctrl_sts_send;
  assign drv  = bus.i_drive_pulse;
  assign smp  = bus.i_sample_pulse;
  assign rx   = bus.i_message_bit;
  assign pbit = bus.i_packetizer_message_bit;

  assign retry_inc = {1'b0, retry} + (RW+1)'(1);
  assign arb = ide ? CNT_W'(33) : CNT_W'(13);

`ifdef YONGA_CAN_TEC_EN
  logic [8:0] tec, tec_n;
  logic [9:0] tec_add;
  logic       cfg_q;
  assign tec_add = {1'b0, tec} + 10'd8;
  assign abort = cfg && state != S_IDLE
              && state != S_BUS_OFF;
`else
  assign abort = cfg && state != S_IDLE;
`endif

  // next-state, counters and outputs
  always_comb begin
    state_n  = state;
    ones_n   = ones;
    bcnt_n   = bcnt;
    ecnt_n   = ecnt;
    tx_n     = tx;
    ide_n    = ide;
    ok_n     = ok;
    retry_n  = retry;
    code_n   = code;
    vld_n    = 1'b0;
    msg_n    = msg;
    pkt_n    = pkt;
    pg_n     = pg;
    err_hit  = 1'b0;
    fail     = 1'b0;
    fail_ifs = 1'b0;
`ifdef YONGA_CAN_TEC_EN
    tec_n    = tec;
`endif
    if (abort) begin
      state_n = S_IDLE;
      pkt_n   = 1'b0;
      pg_n    = 1'b0;
      msg_n   = 1'b1;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (!cfg && send) begin
            state_n = S_SYNC;
            pg_n    = 1'b1;
            retry_n = '0;
          end
        end
        S_SYNC: begin
          if (bus.i_pulse_gen_synced) begin
            state_n = S_WAIT;
            ones_n  = '0;
          end
        end
        S_WAIT: begin
          if (smp) begin
            if (!rx) begin
              ones_n = '0;
            end else if (ones == CNT_W'(IDLE_BITS - 1)) begin
              state_n = S_ARM;
              ones_n  = '0;
              bcnt_n  = '0;
              ide_n   = 1'b0;
              pkt_n   = 1'b1;
            end else begin
              ones_n = ones + 1'b1;
            end
          end
        end
        S_ARM, S_DRIVE: begin
          if (drv) begin
            msg_n   = pbit;
            tx_n    = pbit;
            state_n = S_SAMPLE;
            if (bcnt == CNT_W'(13)) ide_n = pbit;
          end
        end
        S_SAMPLE: begin
          if (smp) begin
            if (bcnt != '1) bcnt_n = bcnt + 1'b1;
            if (bus.i_ack_slot) begin
              if (!rx) begin
                state_n = S_DRIVE;
              end else begin
                code_n  = 3'd1;
                vld_n   = 1'b1;
                err_hit = 1'b1;
              end
            end else if (rx == tx) begin
              if (bus.i_packetizer_rdy) begin
                state_n = S_IFS;
                ok_n    = 1'b1;
                ecnt_n  = '0;
                pkt_n   = 1'b0;
              end else begin
                state_n = S_DRIVE;
              end
            end else if (tx && bcnt < arb) begin
              code_n = 3'd2;
              vld_n  = 1'b1;
              pkt_n  = 1'b0;
              msg_n  = 1'b1;
              fail   = 1'b1;
            end else begin
              code_n  = 3'd4;
              vld_n   = 1'b1;
              err_hit = 1'b1;
            end
          end
        end
        S_FLAG: begin
          if (drv) begin
            msg_n = 1'b0;
            if (ecnt == CNT_W'(ERR_FLAG_BITS - 1)) begin
              state_n = S_DELIM;
              ecnt_n  = '0;
            end else begin
              ecnt_n = ecnt + 1'b1;
            end
          end
        end
        S_DELIM: begin
          if (drv) begin
            msg_n = 1'b1;
            if (ecnt == CNT_W'(ERR_DELIM_BITS - 1)) begin
              state_n = S_IFS;
              ecnt_n  = '0;
              ok_n    = 1'b0;
            end else begin
              ecnt_n = ecnt + 1'b1;
            end
          end
        end
        S_IFS: begin
          if (drv) begin
            msg_n = 1'b1;
            if (ecnt == CNT_W'(IFS_BITS - 1)) begin
              ecnt_n = '0;
              if (ok) begin
                code_n  = 3'd3;
                vld_n   = 1'b1;
                state_n = S_IDLE;
                pg_n    = 1'b0;
`ifdef YONGA_CAN_TEC_EN
                if (tec != '0) tec_n = tec - 9'd1;
`endif
              end else begin
                fail     = 1'b1;
                fail_ifs = 1'b1;
              end
            end else begin
              ecnt_n = ecnt + 1'b1;
            end
          end
        end
`ifdef YONGA_CAN_TEC_EN
        S_BUS_OFF: begin
          if (cfg && !cfg_q) begin
            state_n = S_IDLE;
            tec_n   = '0;
          end
        end
`endif
        default: state_n = S_IDLE;
      endcase

      if (err_hit) begin
        state_n = S_FLAG;
        ecnt_n  = '0;
        pkt_n   = 1'b0;
        ok_n    = 1'b0;
`ifdef YONGA_CAN_TEC_EN
        tec_n = tec_add[9] ? 9'h1FF : tec_add[8:0];
        if (tec_n[8]) begin
          code_n  = 3'd6;
          state_n = S_BUS_OFF;
          msg_n   = 1'b1;
          pg_n    = 1'b0;
        end
`endif
      end

      if (fail) begin
        if (retry_inc > (RW+1)'(MAX_RETRIES)) begin
          code_n  = 3'd5;
          vld_n   = 1'b1;
          state_n = S_IDLE;
          pg_n    = 1'b0;
          pkt_n   = 1'b0;
        end else begin
          retry_n = retry_inc[RW-1:0];
          state_n = S_WAIT;
          ones_n  = fail_ifs ? CNT_W'(IFS_BITS) : '0;
        end
      end
    end
  end

  // state and datapath registers
  always_ff @(posedge i_controller_clk or negedge i_controller_rst_n) begin
    if (!i_controller_rst_n) begin
      state <= S_IDLE;
      ones  <= '0;
      bcnt  <= '0;
      ecnt  <= '0;
      tx    <= 1'b1;
      ide   <= 1'b0;
      ok    <= 1'b0;
      retry <= '0;
      code  <= '0;
      vld   <= 1'b0;
      msg   <= 1'b1;
      pkt   <= 1'b0;
      pg    <= 1'b0;
`ifdef YONGA_CAN_TEC_EN
      tec   <= '0;
      cfg_q <= 1'b0;
`endif
    end else begin
      state <= state_n;
      ones  <= ones_n;
      bcnt  <= bcnt_n;
      ecnt  <= ecnt_n;
      tx    <= tx_n;
      ide   <= ide_n;
      ok    <= ok_n;
      retry <= retry_n;
      code  <= code_n;
      vld   <= vld_n;
      msg   <= msg_n;
      pkt   <= pkt_n;
      pg    <= pg_n;
`ifdef YONGA_CAN_TEC_EN
      tec   <= tec_n;
      cfg_q <= cfg;
`endif
    end
  end

  assign bus.o_packetizer_en = pkt;
  assign bus.o_pulse_gen_en  = pg;
  assign bus.o_message_bit   = msg;
  assign bus.o_sts_code      = code;
  assign bus.o_sts_valid     = vld;
  assign bus.o_retry_cnt     = retry;
`ifdef YONGA_CAN_TEC_EN
  assign bus.o_tec           = tec;
  assign bus.o_err_passive   = tec >= 9'd128;
`endif
endmodule
